// File: rtl/game_pkg.sv
// Shared types, LED encodings and schedule lookup for the level sequencer.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_WIN   = 3'd3,
    ST_LOSE  = 3'd4
  } game_state_t;

  localparam logic [2:0] LED_BARRIER = 3'b100;
  localparam logic [2:0] LED_COIN    = 3'b110;
  localparam logic [2:0] LED_NONE    = 3'b010;

  // Upper bounds for the flattened schedule and a single entry.
  localparam int unsigned SCHED_MAX_W = 4096;
  localparam int unsigned ENTRY_MAX_W = 64;

  // Returns entry k ({barrier_mask, coin_mask}) right-aligned; the caller truncates to its entry width.
  // Indices past the end of the schedule read as zero.
  function automatic logic [ENTRY_MAX_W-1:0] sched_entry(input logic [SCHED_MAX_W-1:0] sched,
                                                         input int unsigned k,
                                                         input int unsigned entry_w);
    logic [SCHED_MAX_W-1:0] shifted;
    shifted = sched >> (k * entry_w);
    return ENTRY_MAX_W'(shifted);
  endfunction

endpackage

// File: rtl/frame_divider.sv
// Tick-enabled wrap counter: pulses o_wrap_c on the tick that completes DIV ticks.
module frame_divider #(
  parameter int unsigned DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_tick,
  input  logic i_clear,
  output logic o_wrap_c
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_top;

  assign w_at_top = (r_cnt == CNT_W'(DIV - 1));
  assign o_wrap_c = i_tick && w_at_top && !i_clear;

  // Count ticks, wrapping at DIV-1; clear has priority.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_tick) begin
      r_cnt <= w_at_top ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/level_sequencer.sv
// Runner-game level sequencer: distance countdown, segment schedule, lane masks and run FSM.
module level_sequencer
  import game_pkg::*;
#(
  parameter int unsigned NUM_LANES      = 3,
  parameter int unsigned NUM_SEGS       = 10,
  parameter int unsigned SEG_LEN        = 20,
  parameter int unsigned TICKS_PER_UNIT = 128,
  parameter int unsigned REFRESH_DIV    = 16,
  parameter int unsigned DIST_W         = 12,
  parameter logic [NUM_SEGS*2*NUM_LANES-1:0] SCHEDULE = '0
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_frame_tick,
  input  logic                             i_enable,
  input  logic                             i_pause,
  input  logic                             i_zero_lives,
  input  logic [NUM_LANES-1:0]             i_coin_hit,
  input  logic [NUM_LANES-1:0]             i_barrier_hit,
  output logic [2:0]                       o_state,
  output logic [$clog2(NUM_SEGS+1)-1:0]    o_segment,
  output logic [DIST_W-1:0]                o_distance,
  output logic [NUM_LANES-1:0]             o_coin_mask,
  output logic [NUM_LANES-1:0]             o_barrier_mask,
  output logic [7:0]                       o_coin_count,
  output logic                             o_refresh,
  output logic [2:0]                       o_led
);

  localparam int unsigned SEG_W      = $clog2(NUM_SEGS + 1);
  localparam int unsigned UNIT_W     = (SEG_LEN > 1) ? $clog2(SEG_LEN) : 1;
  localparam int unsigned ENTRY_W    = 2 * NUM_LANES;
  localparam int unsigned TOTAL_DIST = NUM_SEGS * SEG_LEN;

  game_state_t          r_state, w_state_nxt;
  logic [SEG_W-1:0]     r_segment, w_segment_nxt;
  logic [UNIT_W-1:0]    r_unit, w_unit_nxt;
  logic [DIST_W-1:0]    r_distance, w_distance_nxt;
  logic [NUM_LANES-1:0] r_coin, w_coin_nxt;
  logic [NUM_LANES-1:0] r_barrier, w_barrier_nxt;
  logic [7:0]           r_coin_count, w_count_nxt;
  logic                 r_refresh, w_refresh_nxt;
  logic [2:0]           r_led, w_led_nxt;

  logic                 w_active;
  logic                 w_div_clear;
  logic                 w_tick_run;
  logic                 w_unit_wrap;
  logic                 w_refresh_wrap;
  logic                 w_seg_done;
  logic                 w_last_unit;
  logic                 w_coin_taken;
  logic [ENTRY_W-1:0]   w_entry0;
  logic [ENTRY_W-1:0]   w_entry_load;

  // A RUN cycle that actually advances the game (not leaving for IDLE, PAUSE or LOSE).
  assign w_active    = (r_state == ST_RUN) && i_enable && !i_pause && !i_zero_lives;
  assign w_div_clear = !i_enable || (r_state == ST_IDLE);
  assign w_tick_run  = i_frame_tick && w_active;

  assign w_seg_done   = w_unit_wrap && (r_unit == UNIT_W'(SEG_LEN - 1));
  assign w_last_unit  = w_unit_wrap && (r_distance == DIST_W'(1));
  assign w_coin_taken = |(r_coin & i_coin_hit);

  assign w_entry0     = ENTRY_W'(sched_entry(SCHED_MAX_W'(SCHEDULE), 0, ENTRY_W));
  assign w_entry_load = ENTRY_W'(sched_entry(SCHED_MAX_W'(SCHEDULE), 32'(r_segment) + 32'd1, ENTRY_W));

  frame_divider #(.DIV(TICKS_PER_UNIT)) u_unit_div (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_tick   (w_tick_run),
    .i_clear  (w_div_clear),
    .o_wrap_c (w_unit_wrap)
  );

  frame_divider #(.DIV(REFRESH_DIV)) u_refresh_div (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_tick   (w_tick_run),
    .i_clear  (w_div_clear),
    .o_wrap_c (w_refresh_wrap)
  );

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next state: disable wins everywhere, then lose, then pause, then win.
  always_comb begin
    w_state_nxt = r_state;
    if (!i_enable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_RUN;
        ST_RUN: begin
          if (i_zero_lives)     w_state_nxt = ST_LOSE;
          else if (i_pause)     w_state_nxt = ST_PAUSE;
          else if (w_last_unit) w_state_nxt = ST_WIN;
        end
        ST_PAUSE: begin
          if (i_zero_lives)     w_state_nxt = ST_LOSE;
          else if (!i_pause)    w_state_nxt = ST_RUN;
        end
        ST_WIN, ST_LOSE: w_state_nxt = r_state;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Datapath next values: reinit, lose clear, or distance/segment/mask/coin update.
  always_comb begin
    w_segment_nxt  = r_segment;
    w_unit_nxt     = r_unit;
    w_distance_nxt = r_distance;
    w_coin_nxt     = r_coin;
    w_barrier_nxt  = r_barrier;
    w_count_nxt    = r_coin_count;
    w_refresh_nxt  = r_refresh;

    if (!i_enable || (r_state == ST_IDLE)) begin
      w_segment_nxt  = '0;
      w_unit_nxt     = '0;
      w_distance_nxt = DIST_W'(TOTAL_DIST);
      w_coin_nxt     = '0;
      w_barrier_nxt  = '0;
      w_refresh_nxt  = 1'b0;
      if (i_enable) begin
        w_coin_nxt    = w_entry0[NUM_LANES-1:0];
        w_barrier_nxt = w_entry0[ENTRY_W-1:NUM_LANES];
        w_count_nxt   = '0;
      end
    end else if (i_zero_lives && ((r_state == ST_RUN) || (r_state == ST_PAUSE))) begin
      w_coin_nxt    = '0;
      w_barrier_nxt = '0;
    end else if (w_active) begin
      w_coin_nxt    = r_coin & ~i_coin_hit;
      w_barrier_nxt = r_barrier & ~i_barrier_hit;
      if (w_coin_taken && (r_coin_count != 8'd255)) begin
        w_count_nxt = r_coin_count + 8'd1;
      end
      if (w_unit_wrap) begin
        w_distance_nxt = r_distance - DIST_W'(1);
        if (w_last_unit) begin
          w_segment_nxt = SEG_W'(NUM_SEGS);
          w_unit_nxt    = '0;
          w_coin_nxt    = '0;
          w_barrier_nxt = '0;
        end else if (w_seg_done) begin
          w_segment_nxt = r_segment + SEG_W'(1);
          w_unit_nxt    = '0;
          w_coin_nxt    = w_entry_load[NUM_LANES-1:0];
          w_barrier_nxt = w_entry_load[ENTRY_W-1:NUM_LANES];
        end else begin
          w_unit_nxt = r_unit + UNIT_W'(1);
        end
      end
      if (w_refresh_wrap) begin
        w_refresh_nxt = !r_refresh;
      end
    end

    w_led_nxt = LED_NONE;
    if (w_barrier_nxt != '0)   w_led_nxt = LED_BARRIER;
    else if (w_coin_nxt != '0) w_led_nxt = LED_COIN;
  end

  // Datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_segment    <= '0;
      r_unit       <= '0;
      r_distance   <= DIST_W'(TOTAL_DIST);
      r_coin       <= '0;
      r_barrier    <= '0;
      r_coin_count <= '0;
      r_refresh    <= 1'b0;
      r_led        <= LED_NONE;
    end else begin
      r_segment    <= w_segment_nxt;
      r_unit       <= w_unit_nxt;
      r_distance   <= w_distance_nxt;
      r_coin       <= w_coin_nxt;
      r_barrier    <= w_barrier_nxt;
      r_coin_count <= w_count_nxt;
      r_refresh    <= w_refresh_nxt;
      r_led        <= w_led_nxt;
    end
  end

  assign o_state        = 3'(r_state);
  assign o_segment      = r_segment;
  assign o_distance     = r_distance;
  assign o_coin_mask    = r_coin;
  assign o_barrier_mask = r_barrier & ~i_barrier_hit;
  assign o_coin_count   = r_coin_count;
  assign o_refresh      = r_refresh;
  assign o_led          = r_led;

endmodule
